// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, counter
// widths and the bundle of pipeline-register controls with its builders.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned WAIT_CNT_W  = 8;
  localparam int unsigned STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // Normal flow; a redirect squashes the wrong-path instructions and wins over
  // a load-use stall, which would otherwise hold IF/ID and bubble ID/EX.
  function automatic pipe_ctrl_t run_ctrl(input logic redirect, input logic lu);
    pipe_ctrl_t c;
    c.pc_en        = 1'b1;
    c.if_id_en     = 1'b1;
    c.id_ex_en     = 1'b1;
    c.ex_mem_en    = 1'b1;
    c.mem_wb_en    = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_flush = 1'b0;
    c.mem_wb_flush = 1'b0;
    if (redirect) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (lu) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else begin
      c.pc_en = 1'b1;
    end
    return c;
  endfunction

  // Freeze the front of the pipe and bubble MEM/WB; wb_en=0 freezes it too.
  function automatic pipe_ctrl_t hold_ctrl(input logic wb_en);
    pipe_ctrl_t c;
    c.pc_en        = 1'b0;
    c.if_id_en     = 1'b0;
    c.id_ex_en     = 1'b0;
    c.ex_mem_en    = 1'b0;
    c.mem_wb_en    = wb_en;
    c.if_id_flush  = 1'b0;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_flush = 1'b0;
    c.mem_wb_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_redirect;
  logic                  mem_req;
  logic                  dmem_ready;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic dmem_valid;
  logic bus_err;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_redirect, mem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    input  dmem_valid, bus_err
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_redirect, mem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    output dmem_valid, bus_err
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register
// that the instruction in ID reads (x0 never creates a dependency).
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  lu_o
);

  // Dependency compare against both source operands
  always_comb begin
    lu_o = 1'b0;
    if (ex_mem_read_i && (ex_rd_i != 5'd0)) begin
      lu_o = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
    end else begin
      lu_o = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and data-memory
// wait FSM with timeout. Define PIPE_STALL_CNT_EN to add the stall_cnt output.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_hazard_ctrl_if.slave      bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE_C = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    bus_err_q, bus_err_d;
  logic                    lu_s;
  logic                    mem_stall_s;
  logic                    dmem_valid_s;
  pipe_ctrl_t              ctrl_s;

  load_use_detect u_lu (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .lu_o          (lu_s)
  );

  assign mem_stall_s = bus.mem_req && !bus.dmem_ready;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state logic; a ready in the timeout cycle still completes the access
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q >= TIMEOUT_C) begin
          state_d   = ST_ERR;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE_C;
        end
      end
      ST_ERR: begin
        state_d   = ST_ERR;
        bus_err_d = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output decode; redirect and load-use only matter once memory is not stalling
  always_comb begin
    ctrl_s       = run_ctrl(1'b0, 1'b0);
    dmem_valid_s = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall_s || (state_q == ST_MEM_WAIT && !bus.dmem_ready)) begin
          ctrl_s = hold_ctrl(1'b1);
        end else begin
          ctrl_s = run_ctrl(bus.ex_redirect, lu_s);
        end
        dmem_valid_s = bus.mem_req;
      end
      ST_ERR: begin
        ctrl_s       = hold_ctrl(1'b0);
        dmem_valid_s = 1'b0;
      end
      default: begin
        ctrl_s       = hold_ctrl(1'b0);
        dmem_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.pc_en        = ctrl_s.pc_en;
  assign bus.if_id_en     = ctrl_s.if_id_en;
  assign bus.id_ex_en     = ctrl_s.id_ex_en;
  assign bus.ex_mem_en    = ctrl_s.ex_mem_en;
  assign bus.mem_wb_en    = ctrl_s.mem_wb_en;
  assign bus.if_id_flush  = ctrl_s.if_id_flush;
  assign bus.id_ex_flush  = ctrl_s.id_ex_flush;
  assign bus.ex_mem_flush = ctrl_s.ex_mem_flush;
  assign bus.mem_wb_flush = ctrl_s.mem_wb_flush;
  // An access in flight is dropped the moment reset asserts
  assign bus.dmem_valid   = dmem_valid_s && rst_n;
  assign bus.bus_err      = bus_err_q;

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Free-running stall counter, wraps naturally
  always_comb begin
    if (ctrl_s.pc_en) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// controls, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush, dmem_valid, bus_err}
  localparam logic [10:0] P_NORM    = 11'b11111_0000_0_0;
  localparam logic [10:0] P_LU      = 11'b00111_0100_0_0;
  localparam logic [10:0] P_REDIR   = 11'b11111_1100_0_0;
  localparam logic [10:0] P_REDIR_M = 11'b11111_1100_1_0;
  localparam logic [10:0] P_HOLD    = 11'b00001_0001_1_0;
  localparam logic [10:0] P_RESUME  = 11'b11111_0000_1_0;
  localparam logic [10:0] P_ERR     = 11'b00000_0001_0_1;
  localparam logic [10:0] P_ZERO    = 11'b00000_0000_0_0;
  localparam logic [10:0] M_ALL     = 11'b11111_1111_1_1;
  localparam logic [10:0] M_DV_ERR  = 11'b00000_0000_1_1;

  typedef struct {
    int          id;
    logic [10:0] ctl;
    logic [10:0] mask;
    logic [31:0] sc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  exp_t        sb_q[$];
  exp_t        m;
  logic [10:0] act;
  logic [31:0] sc_model;
  int          vec_id;
  int          n_vec;
  int          n_miss;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                bus.dmem_valid, bus.bus_err};

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic v(input logic rstn, input logic [4:0] rs1, input logic [4:0] rs2,
                   input logic [4:0] rd, input logic mrd, input logic redir,
                   input logic mreq, input logic rdy, input logic [10:0] ctl,
                   input logic [10:0] mask);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rstn;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.ex_rd       = rd;
    bus.ex_mem_read = mrd;
    bus.ex_redirect = redir;
    bus.mem_req     = mreq;
    bus.dmem_ready  = rdy;
    if (!rstn) sc_model = 32'd0;
    e.id   = vec_id;
    e.ctl  = ctl;
    e.mask = mask;
    e.sc   = sc_model;
    sb_q.push_back(e);
    vec_id = vec_id + 1;
    if (rstn && !ctl[10]) sc_model = sc_model + 32'd1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m = sb_q.pop_front();
      n_vec = n_vec + 1;
      if ((act & m.mask) !== (m.ctl & m.mask)) begin
        n_miss = n_miss + 1;
        $display("FAIL vec%0d ctl: got %b expected %b (mask %b)", m.id, act, m.ctl, m.mask);
      end
`ifdef PIPE_STALL_CNT_EN
      if (stall_cnt !== m.sc) begin
        n_miss = n_miss + 1;
        $display("FAIL vec%0d stall_cnt: got %0d expected %0d", m.id, stall_cnt, m.sc);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.ex_rd = 5'd0;
    bus.ex_mem_read = 1'b0; bus.ex_redirect = 1'b0;
    bus.mem_req = 1'b0; bus.dmem_ready = 1'b0;
    sc_model = 32'd0; vec_id = 0; n_vec = 0; n_miss = 0;

    // reset with idle inputs, then release
    v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    // load-use on rs2, then x0 / rs1 / non-load / no-match cases
    v(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, P_LU,   M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, P_LU,   M_ALL);
    v(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b1, 5'd8, 5'd10, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    // redirect beats load-use
    v(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, P_REDIR, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, P_REDIR, M_ALL);
    // fresh stall count, then three memory-wait cycles and resume
    v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM,   M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD,   M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD,   M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD,   M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, P_RESUME, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM,   M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, P_RESUME, M_ALL);
    // redirect ignored while waiting, applied in the resume cycle
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD,    M_ALL);
    v(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, P_HOLD,    M_ALL);
    v(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, P_REDIR_M, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM,    M_ALL);
    // reset in the middle of a wait drops dmem_valid at once
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD, M_ALL);
    v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_ZERO, M_DV_ERR);
    v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    // timeout of 4: entry cycle plus five wait cycles, then ERR is sticky
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD, M_ALL);
    for (int i = 0; i < 5; i++) begin
      v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD, M_ALL);
    end
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_ERR,  M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, P_ERR,  M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, P_ERR,  M_ALL);
    v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM, M_ALL);
    // ready arriving in the timeout cycle wins
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD, M_ALL);
    for (int i = 0; i < 4; i++) begin
      v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_HOLD, M_ALL);
    end
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, P_RESUME, M_ALL);
    v(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NORM,   M_ALL);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_miss = n_miss + 1;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
